rsp_s2_prep_mw_add_seq: RTL and testbench

//  Sequencer for the team's DATA_WIDTH carry adder (rsp_s2_prep_add_u): performs

---
 rtl/rsp_s2_prep_pkg.sv | 10 +
 rtl/rsp_s2_prep_add_u.sv | 14 +
 rtl/rsp_s2_prep_mw_add_seq.sv | 119 +++++++++++
 tb/tb_rsp_s2_prep_mw_add_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsp_s2_prep_pkg.sv
// Shared types for the rsp_s2 prep datapath blocks.
package rsp_s2_prep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } mw_seq_st_t;

endpackage

// File: rtl/rsp_s2_prep_add_u.sv
// DATA_WIDTH ripple-style carry adder: out_num/o_c = num1 + num2 + i_c.
module rsp_s2_prep_add_u #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] num1,
  input  logic [DATA_WIDTH-1:0] num2,
  input  logic                  i_c,
  output logic [DATA_WIDTH-1:0] out_num,
  output logic                  o_c
);

  assign {o_c, out_num} = {1'b0, num1} + {1'b0, num2} + {{DATA_WIDTH{1'b0}}, i_c};

endmodule

// File: rtl/rsp_s2_prep_mw_add_seq.sv
// Multi-word add/subtract sequencer: one word per cycle, LS word first,
// carry chained through a register into the shared word adder.
module rsp_s2_prep_mw_add_seq
  import rsp_s2_prep_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 4,
  parameter int LEN_W      = ($clog2(NUM_WORDS) > 0) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_sub,
  input  logic [LEN_W-1:0]      i_len,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_in_vld,
  output logic                  o_in_rdy,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_out_vld,
  input  logic                  i_out_rdy,
  output logic                  o_out_last,
  output logic                  o_carry,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_WORDS - 1);

  mw_seq_st_t state, state_nxt;

  logic                  sub_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      len_clamp;
  logic [LEN_W-1:0]      cnt;
  logic                  carry_q;
  logic                  acc;
  logic                  is_last;
  logic                  last_hs;
  logic [DATA_WIDTH-1:0] add_b;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_c;

  assign acc       = i_in_vld & o_in_rdy;
  assign is_last   = (cnt == len_q);
  assign last_hs   = o_out_vld & i_out_rdy & o_out_last;
  assign len_clamp = (int'(i_len) > NUM_WORDS - 1) ? MAX_LEN : i_len;
  // Subtract is A + ~B + 1; the +1 comes from seeding the carry reg with i_sub.
  assign add_b     = sub_q ? ~i_b : i_b;

  rsp_s2_prep_add_u #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .num1    (i_a),
    .num2    (add_b),
    .i_c     (carry_q),
    .out_num (add_sum),
    .o_c     (add_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_start)         state_nxt = RUN;
      RUN:     if (acc && is_last)  state_nxt = FLUSH;
      FLUSH:   if (last_hs)         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state != IDLE);
    o_in_rdy = (state == RUN) & (~o_out_vld | i_out_rdy);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sub_q   <= 1'b0;
      len_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
    end else if (state == IDLE && i_start) begin
      sub_q   <= i_sub;
      len_q   <= len_clamp;
      cnt     <= '0;
      carry_q <= i_sub;
    end else if (acc) begin
      cnt     <= cnt + LEN_W'(1);
      carry_q <= add_c;
    end
  end

  // Single output stage; fields only change on a new accept or a drained beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum      <= '0;
      o_out_vld  <= 1'b0;
      o_out_last <= 1'b0;
      o_carry    <= 1'b0;
    end else if (acc) begin
      o_sum      <= add_sum;
      o_out_vld  <= 1'b1;
      o_out_last <= is_last;
      o_carry    <= is_last & add_c;
    end else if (o_out_vld && i_out_rdy) begin
      o_out_vld  <= 1'b0;
      o_out_last <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_done <= 1'b0;
    else          o_done <= (state == FLUSH) & last_hs;
  end

endmodule

// File: tb/tb_rsp_s2_prep_mw_add_seq.sv
// Scoreboard bench: operands are summed as whole integers, split into expected
// result words, and checked by an independent output monitor.
module tb_rsp_s2_prep_mw_add_seq;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0, i_sub = 1'b0, i_in_vld = 1'b0, i_out_rdy = 1'b1;
  logic [LW-1:0] i_len = '0;
  logic [DW-1:0] i_a = '0, i_b = '0;
  logic          o_in_rdy, o_out_vld, o_out_last, o_carry, o_busy, o_done;
  logic [DW-1:0] o_sum;

  rsp_s2_prep_mw_add_seq #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_sub      (i_sub),
    .i_len      (i_len),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_in_vld   (i_in_vld),
    .o_in_rdy   (o_in_rdy),
    .o_sum      (o_sum),
    .o_out_vld  (o_out_vld),
    .i_out_rdy  (i_out_rdy),
    .o_out_last (o_out_last),
    .o_carry    (o_carry),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] sum;
    bit            last;
    bit            carry;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   rdy_force = 1;   // 0: random, 1: always ready, 2: stalled
  bit   bubbles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_force)
      1:       i_out_rdy = 1'b1;
      2:       i_out_rdy = 1'b0;
      default: i_out_rdy = ($urandom % 4) != 0;
    endcase
  end

  // Output monitor: pops on every handshake, checks stall stability and o_done.
  bit            hold_v = 0, expect_done = 0;
  logic [DW-1:0] h_sum;
  logic          h_last, h_carry;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v      = 0;
        expect_done = 0;
      end else begin
        if (expect_done || o_done) chk("o_done", o_done, expect_done);
        expect_done = 0;
        if (hold_v) begin
          chk("hold_vld", o_out_vld, 1);
          chk("hold_sum", o_sum, h_sum);
          chk("hold_last", o_out_last, h_last);
          chk("hold_carry", o_carry, h_carry);
        end
        hold_v = 0;
        if (o_out_vld && i_out_rdy) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got sum %0h with empty scoreboard", o_sum);
          end else begin
            e = sb.pop_front();
            chk("sum", o_sum, e.sum);
            chk("last", o_out_last, e.last);
            if (e.last) begin
              chk("carry", o_carry, e.carry);
              expect_done = 1;
            end
          end
        end else if (o_out_vld) begin
          hold_v  = 1;
          h_sum   = o_sum;
          h_last  = o_out_last;
          h_carry = o_carry;
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (o_busy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (o_busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: o_busy still 1 after %0d cycles", t);
    end
  endtask

  task automatic run_op(input bit sub, input int len, input logic [63:0] a, input logic [63:0] b,
                        input bit bp, input bit poke, input int abort_after);
    logic [64:0] am, bm, r, mask;
    int   n, t, sv;
    bit   c, acc;
    exp_t e;
    n    = len + 1;
    mask = (65'd1 << (DW * n)) - 65'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    if (sub) begin
      r = am - bm;
      c = (am >= bm);
    end else begin
      r = am + bm;
      c = r[DW * n];
    end
    for (int i = 0; i < n; i++) begin
      e.sum   = r[DW*i +: DW];
      e.last  = (i == len);
      e.carry = e.last ? c : 1'b0;
      sb.push_back(e);
    end
    wait_idle();
    i_start = 1; i_sub = sub; i_len = LW'(len);
    @(posedge clk); #1;
    i_start = 0; i_sub = 1'($urandom); i_len = LW'($urandom);
    for (int i = 0; i < n; i++) begin
      if (bubbles && ($urandom % 3) == 0) begin
        i_in_vld = 0;
        @(posedge clk); #1;
      end
      i_in_vld = 1; i_a = a[DW*i +: DW]; i_b = b[DW*i +: DW];
      if (poke && i == 0) begin
        i_start = 1; i_sub = ~sub; i_len = 2'd3;
      end
      t = 0; acc = 0;
      while (!acc && t < 300) begin
        @(negedge clk);
        acc = o_in_rdy;
        @(posedge clk); #1;
        t++;
      end
      i_start = 0;
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: word %0d not accepted", i);
        i_in_vld = 0;
        return;
      end
      if (i == abort_after) begin
        rst_n = 0;
        #1;
        chk("abort_sum", o_sum, 0);
        chk("abort_vld", o_out_vld, 0);
        chk("abort_last", o_out_last, 0);
        chk("abort_carry", o_carry, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_in_rdy", o_in_rdy, 0);
        sb.delete();
        i_in_vld = 0;
        @(posedge clk); #1;
        rst_n = 1;
        return;
      end
      if (bp && i == 0) begin
        sv = rdy_force;
        rdy_force = 2;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_in_rdy", o_in_rdy, 0);
          @(posedge clk); #1;
        end
        rdy_force = sv;
      end
    end
    i_in_vld = 0;
  endtask

  initial begin
    int t;
    #2;
    chk("rst_sum", o_sum, 0);
    chk("rst_vld", o_out_vld, 0);
    chk("rst_last", o_out_last, 0);
    chk("rst_carry", o_carry, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_in_rdy", o_in_rdy, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Operand words offered while idle must not be consumed.
    i_in_vld = 1; i_a = 16'h1234; i_b = 16'h4321;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_in_rdy", o_in_rdy, 0);
      chk("idle_busy", o_busy, 0);
      @(posedge clk); #1;
    end
    i_in_vld = 0;

    run_op(0, 1, 64'h0000_FFFF, 64'h0000_0001, 0, 0, -1);
    run_op(1, 3, 64'h0, 64'h1, 0, 0, -1);
    run_op(0, 3, '1, '1, 0, 0, -1);
    run_op(0, 3, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0, -1);
    run_op(0, 0, 64'h8000, 64'h8000, 0, 1, -1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("poke_stays_idle", o_busy, 0);
    run_op(0, 3, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 1);
    run_op(0, 0, 64'h1, 64'h1, 0, 0, -1);

    rdy_force = 0;
    bubbles   = 1;
    repeat (40)
      run_op(1'($urandom), int'($urandom % 4), {$urandom, $urandom}, {$urandom, $urandom},
             ($urandom % 5) == 0, 0, -1);

    t = 0;
    while ((sb.size() != 0 || o_busy) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0 || o_busy) begin
      total++;
      bad++;
      $display("FAIL drain: %0d beats outstanding, busy=%0b", sb.size(), o_busy);
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
